// File: rtl/rr_trace_beat_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_trace_beat_packer_if                                              |
// | Packet-in / beat-out bundle for the trace beat packer.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rr_trace_beat_packer_if #(
    parameter int IN_WIDTH     = 1024,
    parameter int OUT_WIDTH    = 512,
    parameter int OFFSET_WIDTH = $clog2(IN_WIDTH + 1),
    parameter int CNT_WIDTH    = 32
);
    logic [IN_WIDTH-1:0]     din;
    logic [OFFSET_WIDTH-1:0] din_width;
    logic                    din_valid;
    logic                    din_ready;
    logic                    finish;
    logic [OUT_WIDTH-1:0]    dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_last;
    logic                    finish_done;
    logic [CNT_WIDTH-1:0]    beat_cnt;
    logic [CNT_WIDTH-1:0]    pkt_cnt;
    logic                    width_err;

    modport master (
        output din, din_width, din_valid, finish, dout_ready,
        input  din_ready, dout, dout_valid, dout_last, finish_done,
               beat_cnt, pkt_cnt, width_err
    );

    modport slave (
        input  din, din_width, din_valid, finish, dout_ready,
        output din_ready, dout, dout_valid, dout_last, finish_done,
               beat_cnt, pkt_cnt, width_err
    );
endinterface
`default_nettype wire

// File: rtl/rr_trace_beat_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_trace_beat_packer                                                 |
// | LSB-first packer of variable-width trace packets into AXI beats.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_trace_beat_packer #(
    parameter int IN_WIDTH     = 1024,
    parameter int OUT_WIDTH    = 512,
    parameter int OFFSET_WIDTH = $clog2(IN_WIDTH + 1),
    parameter int FILL_WIDTH   = $clog2(IN_WIDTH + 2*OUT_WIDTH + 1),
    parameter int CNT_WIDTH    = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    rr_trace_beat_packer_if.slave bus
);
    localparam int BUF_WIDTH = IN_WIDTH + OUT_WIDTH;

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_FLUSH = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [FILL_WIDTH-1:0]   c_OUT_FILL  = FILL_WIDTH'(OUT_WIDTH);
    localparam logic [FILL_WIDTH-1:0]   c_OUT2_FILL = FILL_WIDTH'(2*OUT_WIDTH);
    localparam logic [OFFSET_WIDTH-1:0] c_IN_MAX    = OFFSET_WIDTH'(IN_WIDTH);

    logic [1:0]            r_state;
    logic [BUF_WIDTH-1:0]  r_buf;
    logic [FILL_WIDTH-1:0] r_fill;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic                  r_width_err;
    logic                  r_live;

    logic                    w_dout_valid;
    logic                    w_din_ready;
    logic                    w_pop;
    logic                    w_accept;
    logic                    w_over;
    logic [OFFSET_WIDTH-1:0] w_width;
    logic [IN_WIDTH-1:0]     w_mask;
    logic [FILL_WIDTH-1:0]   w_fill_after_pop;
    logic [BUF_WIDTH-1:0]    w_buf_after_pop;
    logic [BUF_WIDTH-1:0]    w_pkt;

    always_comb begin
        w_dout_valid = 1'b0;
        if (r_state == c_ST_RUN)
            w_dout_valid = (r_fill >= c_OUT_FILL);
        else if (r_state == c_ST_FLUSH)
            w_dout_valid = (r_fill != '0);
    end

    // r_live keeps din_ready low until the first edge after reset release
    assign w_din_ready = r_live && (r_state == c_ST_RUN) &&
                         ((r_fill < c_OUT_FILL) ||
                          (bus.dout_ready && (r_fill < c_OUT2_FILL)));

    assign w_pop    = w_dout_valid && bus.dout_ready;
    assign w_accept = bus.din_valid && w_din_ready;

    assign w_over  = (bus.din_width > c_IN_MAX);
    assign w_width = w_over ? c_IN_MAX : bus.din_width;
    assign w_mask  = ~({IN_WIDTH{1'b1}} << w_width);

    assign w_fill_after_pop = r_fill -
        (w_pop ? ((r_fill < c_OUT_FILL) ? r_fill : c_OUT_FILL) : '0);
    assign w_buf_after_pop  = w_pop ? (r_buf >> OUT_WIDTH) : r_buf;
    assign w_pkt = {{OUT_WIDTH{1'b0}}, bus.din & w_mask} << w_fill_after_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_RUN;
            r_buf       <= '0;
            r_fill      <= '0;
            r_beat_cnt  <= '0;
            r_pkt_cnt   <= '0;
            r_width_err <= 1'b0;
            r_live      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_pop)
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            if (w_accept) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
                if (w_over)
                    r_width_err <= 1'b1;
            end
            case (r_state)
                c_ST_RUN: begin
                    r_buf  <= w_accept ? (w_buf_after_pop | w_pkt) : w_buf_after_pop;
                    r_fill <= w_fill_after_pop +
                              (w_accept ? FILL_WIDTH'(w_width) : '0);
                    if (bus.finish)
                        r_state <= c_ST_FLUSH;
                end
                c_ST_FLUSH: begin
                    r_buf  <= w_buf_after_pop;
                    r_fill <= w_fill_after_pop;
                    if (w_fill_after_pop == '0)
                        r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_buf   <= '0;
                    r_fill  <= '0;
                    r_state <= c_ST_RUN;
                end
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

    // Bits above fill are always zero, so a partial flush beat is zero-padded
    assign bus.dout        = r_buf[OUT_WIDTH-1:0];
    assign bus.dout_valid  = w_dout_valid;
    assign bus.dout_last   = w_dout_valid && (r_state == c_ST_FLUSH) &&
                             (r_fill <= c_OUT_FILL);
    assign bus.din_ready   = w_din_ready;
    assign bus.finish_done = (r_state == c_ST_DONE);
    assign bus.beat_cnt    = r_beat_cnt;
    assign bus.pkt_cnt     = r_pkt_cnt;
    assign bus.width_err   = r_width_err;
endmodule
`default_nettype wire

// File: tb/tb_rr_trace_beat_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_trace_beat_packer                                              |
// | Directed self-checking bench for rr_trace_beat_packer.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rr_trace_beat_packer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_trace_beat_packer_if bus ();

    rr_trace_beat_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [1023:0] p_a;
    logic [1023:0] p_b;
    logic [511:0]  exp_beat;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n          = 1'b0;
        bus.din        = '0;
        bus.din_width  = '0;
        bus.din_valid  = 1'b0;
        bus.finish     = 1'b0;
        bus.dout_ready = 1'b0;

        // Reset state
        repeat (10) step();
        chk("rst_din_ready",  bus.din_ready, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_dout_last",  bus.dout_last, 0);
        chk("rst_dout",       bus.dout, 0);
        chk("rst_beat_cnt",   bus.beat_cnt, 0);
        chk("rst_pkt_cnt",    bus.pkt_cnt, 0);
        chk("rst_width_err",  bus.width_err, 0);
        chk("rst_finish_done", bus.finish_done, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_din_ready_pre", bus.din_ready, 0);
        step();
        chk("rel_din_ready", bus.din_ready, 1);

        // Two 300-bit all-ones packets (upper din bits also ones, must be masked)
        bus.din        = '1;
        bus.din_width  = 11'd300;
        bus.din_valid  = 1'b1;
        bus.dout_ready = 1'b1;
        step();
        step();
        bus.din_valid = 1'b0;
        #1;
        chk("t2_valid", bus.dout_valid, 1);
        chk("t2_beat",  bus.dout, {512{1'b1}});
        chk("t2_last",  bus.dout_last, 0);
        step();
        chk("t2_beat_cnt", bus.beat_cnt, 1);
        chk("t2_pkt_cnt",  bus.pkt_cnt, 2);
        chk("t2_valid_after", bus.dout_valid, 0);
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        exp_beat = '0;
        exp_beat[87:0] = '1;
        chk("t2_flush_valid", bus.dout_valid, 1);
        chk("t2_flush_beat",  bus.dout, exp_beat);
        chk("t2_flush_last",  bus.dout_last, 1);
        chk("t2_flush_fd",    bus.finish_done, 0);
        step();
        chk("t2_done_fd",     bus.finish_done, 1);
        chk("t2_done_beats",  bus.beat_cnt, 2);
        chk("t2_done_pkts",   bus.pkt_cnt, 2);
        chk("t2_done_ready",  bus.din_ready, 0);
        chk("t2_done_valid",  bus.dout_valid, 0);
        step();
        chk("t2_run_fd",      bus.finish_done, 0);
        chk("t2_run_ready",   bus.din_ready, 1);

        // One full 1024-bit packet: two full beats, no flush beat
        p_a = rnd1024();
        bus.din       = p_a;
        bus.din_width = 11'd1024;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        #1;
        chk("t3_b0",      bus.dout, p_a[511:0]);
        chk("t3_b0_last", bus.dout_last, 0);
        step();
        chk("t3_b1",       bus.dout, p_a[1023:512]);
        chk("t3_b1_valid", bus.dout_valid, 1);
        chk("t3_b1_last",  bus.dout_last, 0);
        step();
        chk("t3_empty", bus.dout_valid, 0);
        chk("t3_beats", bus.beat_cnt, 4);
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        chk("t3_flush_valid", bus.dout_valid, 0);
        chk("t3_flush_fd",    bus.finish_done, 0);
        step();
        chk("t3_done_fd",     bus.finish_done, 1);
        chk("t3_done_beats",  bus.beat_cnt, 4);
        step();

        // Backpressure at fill 600, then pop and accept in the same cycle
        bus.dout_ready = 1'b0;
        p_a = rnd1024();
        p_b = rnd1024();
        bus.din       = p_a;
        bus.din_width = 11'd600;
        bus.din_valid = 1'b1;
        step();
        bus.din       = p_b;
        bus.din_width = 11'd40;
        #1;
        chk("t4_ready_blocked", bus.din_ready, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_hold_valid", bus.dout_valid, 1);
            chk("t4_hold_beat",  bus.dout, p_a[511:0]);
        end
        chk("t4_hold_pkts", bus.pkt_cnt, 4);
        bus.dout_ready = 1'b1;
        #1;
        chk("t4_ready_open", bus.din_ready, 1);
        step();
        bus.din_valid = 1'b0;
        #1;
        chk("t4_pkts",  bus.pkt_cnt, 5);
        chk("t4_beats", bus.beat_cnt, 5);
        chk("t4_valid", bus.dout_valid, 0);
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        exp_beat = '0;
        exp_beat[87:0]   = p_a[599:512];
        exp_beat[127:88] = p_b[39:0];
        chk("t4_flush_beat", bus.dout, exp_beat);
        chk("t4_flush_last", bus.dout_last, 1);
        step();
        chk("t4_done_fd", bus.finish_done, 1);
        step();

        // Oversized din_width clamps to 1024 and sets width_err
        p_a = rnd1024();
        bus.din       = p_a;
        bus.din_width = 11'd1100;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        #1;
        chk("t5_err",  bus.width_err, 1);
        chk("t5_b0",   bus.dout, p_a[511:0]);
        step();
        chk("t5_b1",   bus.dout, p_a[1023:512]);
        step();
        chk("t5_empty", bus.dout_valid, 0);
        p_b = rnd1024();
        bus.din       = p_b;
        bus.din_width = 11'd40;
        bus.din_valid = 1'b1;
        bus.finish    = 1'b1;
        step();
        bus.din_valid = 1'b0;
        bus.finish    = 1'b0;
        #1;
        exp_beat = '0;
        exp_beat[39:0] = p_b[39:0];
        chk("t5_flush_beat", bus.dout, exp_beat);
        chk("t5_flush_last", bus.dout_last, 1);
        chk("t5_pkts",       bus.pkt_cnt, 7);
        chk("t5_err_sticky", bus.width_err, 1);
        step();
        chk("t5_done_fd",    bus.finish_done, 1);
        chk("t5_done_beats", bus.beat_cnt, 9);
        step();

        // Zero-width packet, then 200 bits, then reset mid-FLUSH
        bus.din       = '1;
        bus.din_width = 11'd0;
        bus.din_valid = 1'b1;
        step();
        chk("t6_zero_pkts",  bus.pkt_cnt, 8);
        chk("t6_zero_valid", bus.dout_valid, 0);
        p_a = rnd1024();
        bus.din        = p_a;
        bus.din_width  = 11'd200;
        bus.dout_ready = 1'b0;
        step();
        bus.din_valid = 1'b0;
        bus.finish    = 1'b1;
        step();
        bus.finish = 1'b0;
        step();
        exp_beat = '0;
        exp_beat[199:0] = p_a[199:0];
        chk("t6_flush_beat",  bus.dout, exp_beat);
        chk("t6_flush_valid", bus.dout_valid, 1);
        chk("t6_flush_last",  bus.dout_last, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.dout_valid, 0);
        chk("t6_rst_last",  bus.dout_last, 0);
        chk("t6_rst_beats", bus.beat_cnt, 0);
        chk("t6_rst_pkts",  bus.pkt_cnt, 0);
        chk("t6_rst_err",   bus.width_err, 0);
        chk("t6_rst_dout",  bus.dout, 0);
        chk("t6_rst_ready", bus.din_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_rst_fd", bus.finish_done, 0);
        end
        rst_n = 1'b1;
        step();
        chk("t6_rel_ready", bus.din_ready, 1);
        chk("t6_rel_fd",    bus.finish_done, 0);
        chk("t6_rel_valid", bus.dout_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
